hwpe_ctrl_offloader: RTL
========================

HWPE_CTRL_OFFLOADER -- requirements
Module: hwpe_ctrl_offloader

Interface
REQ-001 SHALL have parameter N_JOB_REGS, default 4: number of job registers written per offload (1..16).
REQ-002 SHALL have parameter ID_WIDTH, default 16: width of the cfg.id field.
REQ-003 SHALL have parameter CORE_IDX, default 0: index of the single bit set in cfg.id.
REQ-004 SHALL have parameter BACKOFF_CYCLES, default 8: idle cycles between failed context acquisitions.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-008 SHALL have port cfg, hwpe_ctrl_intf_periph.master: peripheral initiator toward the accelerator slave.
REQ-009 SHALL have port job_valid_i, input, 1 bit: job request.
REQ-010 SHALL have port job_ready_o, output, 1 bit: job accepted (FSM in IDLE).
REQ-011 SHALL have port job_data_i, input, N_JOB_REGS x 32 bits: job register values, sampled on accept.
REQ-012 SHALL have port evt_i, input, 1 bit: done event from the accelerator (the evt[CORE_IDX][0] line).
REQ-013 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse on job completion.
REQ-015 SHALL have port context_o, output, 8 bits: context ID returned by the last successful acquire.
REQ-016 SHALL have port retries_o, output, 16 bits: failed acquires for the current job, saturating at 0xFFFF.

Function
REQ-017 SHALL drive register accesses as byte address = 4*register index, with be=4'hF and cfg.id one-hot at bit CORE_IDX.
REQ-018 SHALL hold req, add, wen, data and be stable from assertion until the cycle gnt=1, then deassert req in the next cycle unless another access follows.
REQ-019 SHALL treat a read as complete only on r_valid=1, capture r_data in that cycle, and keep at most one read outstanding.
REQ-020 SHALL implement the FSM states IDLE, ACQ_REQ, ACQ_WAIT, BACKOFF, WRITE, TRIGGER, WAIT_EVT, DONE.
REQ-021 IDLE: job_ready_o=1; job_valid_i=1 SHALL latch job_data_i, clear retries_o, and go to ACQ_REQ.
REQ-022 ACQ_REQ: SHALL issue a read (wen=1) of register 1 (test&set) and go to ACQ_WAIT on gnt.
REQ-023 ACQ_WAIT: on r_valid, r_data[31]=1 (no free context) SHALL increment retries_o and go to BACKOFF; otherwise SHALL store r_data[7:0] in context_o and go to WRITE.
REQ-024 BACKOFF: SHALL count exactly BACKOFF_CYCLES cycles, then go to ACQ_REQ; BACKOFF_CYCLES=0 SHALL go to ACQ_REQ in the next cycle.
REQ-025 WRITE: SHALL write job word k to register FIRST_JOB_REG+k, k=0..N_JOB_REGS-1 in order, one per granted cycle, with back-to-back writes allowed; after the last grant it SHALL go to TRIGGER.
REQ-026 TRIGGER: SHALL write 0 to register 0 and go to WAIT_EVT on gnt.
REQ-027 WAIT_EVT: evt_i=1 SHALL go to DONE; an evt_i seen in any other state SHALL be ignored.
REQ-028 DONE: SHALL pulse done_o for one cycle and return to IDLE; minimum job latency with gnt always 1 and r_valid one cycle after gnt is 5+N_JOB_REGS cycles from accept to done_o.
REQ-029 clear_i=1 SHALL return the FSM to IDLE, drop req immediately, and clear the backoff counter in the same edge; a pending r_valid afterwards SHALL be ignored; context_o and retries_o SHALL be kept.

Reset
REQ-030 On rst_ni=0, state SHALL be IDLE and req=0, add=0, wen=1, data=0, done_o=0, context_o=0, retries_o=0, latched job=0.
REQ-031 busy_o=0 and job_ready_o=1 SHALL hold from the first cycle after reset release.

Structure
REQ-032 SHALL place the FSM state enum, FIRST_JOB_REG (=REGFILE_N_MANDATORY_REGS+REGFILE_N_RESERVED_REGS), TESTSET_IDX=1 and TRIGGER_IDX=0 in hwpe_ctrl_package.
REQ-033 SHALL be a single module with no sub-modules; the backoff counter and the write index counter are inline.

Verification
REQ-034 Slave with gnt=1 and test&set returning 0x00000001, N_JOB_REGS=4 -> writes at 0x1C..0x28 (given FIRST_JOB_REG=7), trigger at 0x00, evt_i 3 cycles later -> done_o pulse, context_o=1.
REQ-035 Test&set returns 0xFFFFFFFF twice, then 0 -> retries_o=2, each retry read starts exactly BACKOFF_CYCLES after r_valid, context_o=0.
REQ-036 gnt randomly low 50% of cycles -> all request fields stable while req=1 and gnt=0, write order and data exact, no lost or duplicate writes.
REQ-037 clear_i asserted in WRITE after 2 of 4 writes -> req=0 the next cycle, IDLE, job_ready_o=1, a new job completes normally.
REQ-038 evt_i pulse while in IDLE, then a job -> no spurious done_o, done_o only after the trigger write and the next evt_i.
REQ-039 rst_ni asserted in WAIT_EVT -> all outputs take reset values asynchronously, no cfg.req after release until job_valid_i.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE control offloader.
// Contents: register-file layout constants, the offloader FSM state type and
// a helper that turns a register index into a byte address.
package hwpe_ctrl_package;

  localparam int unsigned REGFILE_N_MANDATORY_REGS = 7;
  localparam int unsigned REGFILE_N_RESERVED_REGS  = 0;
  localparam int unsigned FIRST_JOB_REG = REGFILE_N_MANDATORY_REGS + REGFILE_N_RESERVED_REGS;
  localparam int unsigned TESTSET_IDX   = 1;
  localparam int unsigned TRIGGER_IDX   = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACQ_REQ  = 3'd1,
    ACQ_WAIT = 3'd2,
    BACKOFF  = 3'd3,
    WRITE    = 3'd4,
    TRIGGER  = 3'd5,
    WAIT_EVT = 3'd6,
    DONE     = 3'd7
  } offload_state_e;

  // Registers are 32-bit words, so the byte address is index*4.
  function automatic logic [31:0] reg_addr(input int unsigned idx);
    return 32'(idx) << 2;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral (register) interface between an initiator and an HWPE slave.
// master: drives req/add/wen/be/data/id, receives gnt/r_data/r_valid.
// slave : the mirror image.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = 16
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/hwpe_ctrl_offloader.sv
// Offloads one job to an HWPE accelerator over its peripheral port:
// acquire a context (test&set read, with back-off on failure), write the job
// registers, write the trigger register, then wait for the done event.
// Ports:
//   clk_i, rst_ni, clear_i      clock, async active-low reset, sync soft clear
//   cfg                         peripheral initiator toward the accelerator
//   job_valid_i / job_ready_o   job handshake (ready while idle)
//   job_data_i                  N_JOB_REGS words, sampled on accept
//   evt_i                       accelerator done event
//   busy_o, done_o              activity flag, one-cycle completion pulse
//   context_o, retries_o        acquired context ID, failed acquires (saturating)
module hwpe_ctrl_offloader
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_JOB_REGS     = 4,
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned CORE_IDX       = 0,
  parameter int unsigned BACKOFF_CYCLES = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  hwpe_ctrl_intf_periph.master        cfg,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  logic [N_JOB_REGS-1:0][31:0] job_data_i,
  input  logic                        evt_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [7:0]                  context_o,
  output logic [15:0]                 retries_o
);

  localparam int unsigned IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam int unsigned BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

  offload_state_e              state_r, state_s;
  logic [IDX_W-1:0]            wr_idx_r, wr_idx_s;
  logic [BO_W-1:0]             bo_cnt_r, bo_cnt_s;
  logic                        stale_r, stale_s;
  logic                        read_open_s;
  logic                        accept_s, retry_s, acquire_s;
  logic [N_JOB_REGS-1:0][31:0] job_r;

  logic        req_r, req_s;
  logic [31:0] add_r, add_s;
  logic        wen_r, wen_s;
  logic [31:0] data_r, data_s;
  logic        done_r;
  logic [7:0]  context_r;
  logic [15:0] retries_r;

  assign cfg.req  = req_r;
  assign cfg.add  = add_r;
  assign cfg.wen  = wen_r;
  assign cfg.data = data_r;
  assign cfg.be   = 4'hF;
  assign cfg.id   = ID_WIDTH'(1'b1) << CORE_IDX;

  assign job_ready_o = (state_r == IDLE);
  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;
  assign context_o   = context_r;
  assign retries_o   = retries_r;

  // A read is still in flight if it was granted this cycle or its r_valid has not arrived.
  assign read_open_s = ((state_r == ACQ_REQ) && req_r && cfg.gnt) ||
                       ((state_r == ACQ_WAIT) && !cfg.r_valid);

  // Next-state logic, counters and the next values of the request fields.
  always_comb begin
    state_s   = state_r;
    wr_idx_s  = wr_idx_r;
    bo_cnt_s  = bo_cnt_r;
    accept_s  = 1'b0;
    retry_s   = 1'b0;
    acquire_s = 1'b0;
    req_s     = 1'b0;
    add_s     = 32'h0000_0000;
    wen_s     = 1'b1;
    data_s    = 32'h0000_0000;

    // A read abandoned by a clear still returns r_valid; swallow it here.
    if (stale_r && cfg.r_valid) begin
      stale_s = 1'b0;
    end else begin
      stale_s = stale_r;
    end

    case (state_r)
      IDLE: begin
        if (job_valid_i) begin
          accept_s = 1'b1;
          state_s  = ACQ_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      ACQ_REQ: begin
        if (req_r && cfg.gnt) begin
          state_s = ACQ_WAIT;
        end else begin
          state_s = ACQ_REQ;
        end
      end
      ACQ_WAIT: begin
        if (cfg.r_valid) begin
          if (cfg.r_data[31]) begin
            retry_s  = 1'b1;
            bo_cnt_s = '0;
            // With no back-off the retry read follows directly.
            if (BACKOFF_CYCLES == 32'd0) begin
              state_s = ACQ_REQ;
            end else begin
              state_s = BACKOFF;
            end
          end else begin
            acquire_s = 1'b1;
            wr_idx_s  = '0;
            state_s   = WRITE;
          end
        end else begin
          state_s = ACQ_WAIT;
        end
      end
      BACKOFF: begin
        if (32'(bo_cnt_r) == BACKOFF_CYCLES - 32'd1) begin
          state_s = ACQ_REQ;
        end else begin
          bo_cnt_s = bo_cnt_r + BO_W'(1);
        end
      end
      WRITE: begin
        if (cfg.gnt) begin
          if (32'(wr_idx_r) == N_JOB_REGS - 32'd1) begin
            state_s = TRIGGER;
          end else begin
            wr_idx_s = wr_idx_r + IDX_W'(1);
          end
        end else begin
          state_s = WRITE;
        end
      end
      TRIGGER: begin
        if (cfg.gnt) begin
          state_s = WAIT_EVT;
        end else begin
          state_s = TRIGGER;
        end
      end
      WAIT_EVT: begin
        if (evt_i) begin
          state_s = DONE;
        end else begin
          state_s = WAIT_EVT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (clear_i) begin
      state_s   = IDLE;
      bo_cnt_s  = '0;
      wr_idx_s  = '0;
      accept_s  = 1'b0;
      retry_s   = 1'b0;
      acquire_s = 1'b0;
      stale_s   = stale_s | read_open_s;
    end else begin
      stale_s = stale_s;
    end

    // Request fields follow the state being entered so they are registered
    // and stay constant for as long as the state waits for gnt.
    case (state_s)
      ACQ_REQ: begin
        req_s  = !stale_s;
        add_s  = reg_addr(TESTSET_IDX);
        wen_s  = 1'b1;
        data_s = 32'h0000_0000;
      end
      WRITE: begin
        req_s  = 1'b1;
        add_s  = reg_addr(FIRST_JOB_REG + 32'(wr_idx_s));
        wen_s  = 1'b0;
        data_s = job_r[wr_idx_s];
      end
      TRIGGER: begin
        req_s  = 1'b1;
        add_s  = reg_addr(TRIGGER_IDX);
        wen_s  = 1'b0;
        data_s = 32'h0000_0000;
      end
      default: begin
        req_s  = 1'b0;
        add_s  = 32'h0000_0000;
        wen_s  = 1'b1;
        data_s = 32'h0000_0000;
      end
    endcase
  end

  // State, counters and the stale-read flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      wr_idx_r <= '0;
      bo_cnt_r <= '0;
      stale_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      wr_idx_r <= wr_idx_s;
      bo_cnt_r <= bo_cnt_s;
      stale_r  <= stale_s;
    end
  end

  // Registered peripheral request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_r  <= 1'b0;
      add_r  <= 32'h0000_0000;
      wen_r  <= 1'b1;
      data_r <= 32'h0000_0000;
    end else begin
      req_r  <= req_s;
      add_r  <= add_s;
      wen_r  <= wen_s;
      data_r <= data_s;
    end
  end

  // Job latch and status outputs; context and retries survive a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_r     <= '0;
      done_r    <= 1'b0;
      context_r <= 8'h00;
      retries_r <= 16'h0000;
    end else begin
      done_r <= (state_s == DONE);
      if (accept_s) begin
        job_r     <= job_data_i;
        retries_r <= 16'h0000;
      end else if (retry_s && (retries_r != 16'hFFFF)) begin
        retries_r <= retries_r + 16'd1;
      end else begin
        retries_r <= retries_r;
      end
      if (acquire_s) begin
        context_r <= cfg.r_data[7:0];
      end else begin
        context_r <= context_r;
      end
    end
  end

endmodule
